// File: rtl/output_7seg_scan.sv
// output_7seg_scan: time-multiplexed seven-segment driver with a
// double-buffered display value, a ghost-guard slot per digit, leading-zero
// blanking and a whole-display blink.
module output_7seg_scan #(
  parameter int DIGITS         = 4,
  parameter int PRESCALE       = 1000,
  parameter int BLINK_FRAMES   = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  input  logic                  enable,
  input  logic                  blank_lz,
  input  logic                  blink_en,
  output logic [6:0]            segments,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_done
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0]     PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [BW-1:0]     BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [6:0]        SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic              DP_OFF     = SEG_ACTIVE_LOW;
  localparam logic [DIGITS-1:0] DIG_OFF    = DIG_ACTIVE_LOW ? '1 : '0;

  logic [4*DIGITS-1:0] shadow_val;
  logic [DIGITS-1:0]   shadow_dp;
  logic [4*DIGITS-1:0] active_val;
  logic [DIGITS-1:0]   active_dp;
  logic                pending;
  logic [PW-1:0]       presc;
  logic [IW-1:0]       idx;
  logic [BW-1:0]       blink_cnt;
  logic                blink_phase;

  logic                last_slot;
  logic                last_digit;
  logic                boundary;
  logic                transfer_ok;
  logic                dark;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_blank;
  logic [DIGITS-1:0]   lz_blank;
  logic                upper_zero;
  logic [DIGITS-1:0]   onehot;

  // Full hexadecimal glyph table, bit0 = a ... bit6 = g, lit = 1.
  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h3F;
      4'h1: decode = 7'h06;
      4'h2: decode = 7'h5B;
      4'h3: decode = 7'h4F;
      4'h4: decode = 7'h66;
      4'h5: decode = 7'h6D;
      4'h6: decode = 7'h7D;
      4'h7: decode = 7'h07;
      4'h8: decode = 7'h7F;
      4'h9: decode = 7'h6F;
      4'hA: decode = 7'h77;
      4'hB: decode = 7'h7C;
      4'hC: decode = 7'h39;
      4'hD: decode = 7'h5E;
      4'hE: decode = 7'h79;
      default: decode = 7'h71;
    endcase
  endfunction

  assign last_slot   = (presc == PRESC_LAST);
  assign last_digit  = (idx == IDX_LAST);
  assign boundary    = enable && last_slot && last_digit;
  assign transfer_ok = boundary || !enable;
  assign dark        = blink_en && !blink_phase;
  assign onehot      = DIGITS'(1) << idx;

  // Select the digit being scanned and work out leading-zero blanking from the top digit down.
  always_comb begin
    cur_nib    = 4'h0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    lz_blank   = '0;
    upper_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      upper_zero  = upper_zero && (active_val[4*k +: 4] == 4'h0);
      lz_blank[k] = blank_lz && upper_zero && (k != 0);
    end
    for (int k = 0; k < DIGITS; k++) begin
      if (IW'(k) == idx) begin
        cur_nib   = active_val[4*k +: 4];
        cur_dp    = active_dp[k];
        cur_blank = lz_blank[k];
      end
    end
  end

  // Double buffer: loads land in shadow and move to active only at a frame boundary or while parked.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      active_val <= '0;
      active_dp  <= '0;
      pending    <= 1'b0;
    end else if (load) begin
      shadow_val <= value;
      shadow_dp  <= dp;
      if (transfer_ok) begin
        active_val <= value;
        active_dp  <= dp;
        pending    <= 1'b0;
      end else begin
        pending    <= 1'b1;
      end
    end else if (pending && transfer_ok) begin
      active_val <= shadow_val;
      active_dp  <= shadow_dp;
      pending    <= 1'b0;
    end
  end

  // Slot prescaler, digit index and per-frame blink counter; all parked at zero while disabled.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      presc       <= '0;
      idx         <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (!enable) begin
      presc       <= '0;
      idx         <= '0;
      blink_cnt   <= '0;
    end else if (last_slot) begin
      presc <= '0;
      if (last_digit) begin
        idx <= '0;
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end else begin
        idx <= idx + IW'(1);
      end
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Registered pin drivers; the first cycle of each slot keeps every digit off to hide ghosting.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      segments   <= SEG_OFF;
      dp_out     <= DP_OFF;
      digit_sel  <= DIG_OFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (!enable || dark) begin
        segments  <= SEG_OFF;
        dp_out    <= DP_OFF;
        digit_sel <= DIG_OFF;
      end else begin
        if (cur_blank) segments <= SEG_OFF;
        else           segments <= SEG_ACTIVE_LOW ? ~decode(cur_nib) : decode(cur_nib);
        dp_out <= SEG_ACTIVE_LOW ? ~cur_dp : cur_dp;
        if (presc == '0) digit_sel <= DIG_OFF;
        else             digit_sel <= DIG_ACTIVE_LOW ? ~onehot : onehot;
      end
    end
  end

endmodule
